// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the clients and the round-robin arbiter.
// master is the client side; slave is the arbiter.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       expired;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  expired
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output expired
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with bounded hold time and a one-cycle
// turnaround between owners; all state moves on the falling clock edge.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  rr_arbiter4_if.slave bus
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] gid_q, gid_d;
  logic       exp_q, exp_d;

  logic [1:0] idx;
  logic [1:0] win;
  logic       found;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    exp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          grant_d = 4'b0001 << win;
          gid_d   = win;
          cnt_d   = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!bus.req[gid_q]) begin
          grant_d = '0;
          ptr_d   = gid_q + 2'd1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          grant_d = '0;
          ptr_d   = gid_q + 2'd1;
          exp_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = |grant_q;
  assign bus.expired  = exp_q;

endmodule
